// File: rtl/bounce_counter_pkg.sv
// bounce_counter_pkg: mode and direction encodings shared by the LED sequencer
package bounce_counter_pkg;
    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;
endpackage

// File: rtl/bounce_counter_tick_gen.sv
// tick_gen: prescaler producing a registered one-clk tick every DIV_COUNT enabled cycles
module tick_gen #(
    parameter int DIV_COUNT = 1500000,
    parameter int DIV_WIDTH = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1
) (
    input  logic clk,
    input  logic rst_btn,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(DIV_COUNT - 1);
    logic [DIV_WIDTH-1:0] cnt;
    // count 0..LAST while enabled; a clear or disable restarts the period from zero
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr || !en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
            tick <= cnt == LAST;
        end
    end
endmodule

// File: rtl/bounce_counter.sv
// bounce_counter: LED sequencer counter with up/down wrap, ping-pong and hold modes
module bounce_counter
    import bounce_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MIN_COUNT = 0,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int DIV_COUNT = 1500000,
    parameter int DIV_WIDTH = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1
) (
    input  logic             clk,
    input  logic             rst_btn,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tick,
    output logic             edge_p
);
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_COUNT);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    dir_t             dir_q, dir_d;
    mode_t            mode_m;
    logic [WIDTH-1:0] count_d, up_v, dn_v, clamped;
    logic             edge_d;
    int               lv;
    assign mode_m  = mode_t'(mode);
    assign dir     = dir_q;
    assign up_v    = count + 1'b1;
    assign dn_v    = count - 1'b1;
    assign lv      = int'(load_val);
    assign clamped = lv < MIN_COUNT ? MIN_V : lv > MAX_COUNT ? MAX_V : load_val;
    tick_gen #(.DIV_COUNT(DIV_COUNT), .DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clk     (clk),
        .rst_btn (rst_btn),
        .en      (en),
        .clr     (load),
        .tick    (tick)
    );
    // next count/direction: load wins, otherwise step on an enabled tick
    always_comb begin
        count_d = count;
        dir_d   = dir_q;
        edge_d  = 1'b0;
        if (load) begin
            count_d = clamped;
        end else if (tick && en) begin
            case (mode_m)
                MODE_UP: begin
                    count_d = count == MAX_V ? MIN_V : up_v;
                    dir_d   = DIR_UP;
                    edge_d  = count == MAX_V;
                end
                MODE_DOWN: begin
                    count_d = count == MIN_V ? MAX_V : dn_v;
                    dir_d   = DIR_DOWN;
                    edge_d  = count == MIN_V;
                end
                MODE_BOUNCE: begin
                    if (MIN_V == MAX_V) begin
                        edge_d = 1'b1;
                    end else if ((dir_q == DIR_UP && count != MAX_V) || (dir_q == DIR_DOWN && count == MIN_V)) begin
                        count_d = up_v;
                        dir_d   = up_v == MAX_V ? DIR_DOWN : DIR_UP;
                        edge_d  = up_v == MAX_V;
                    end else begin
                        count_d = dn_v;
                        dir_d   = dn_v == MIN_V ? DIR_UP : DIR_DOWN;
                        edge_d  = dn_v == MIN_V;
                    end
                end
                default: ;
            endcase
        end
    end
    // count, direction and endpoint pulse registers
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            count  <= MIN_V;
            dir_q  <= DIR_UP;
            edge_p <= 1'b0;
        end else begin
            count  <= count_d;
            dir_q  <= dir_d;
            edge_p <= edge_d;
        end
    end
endmodule

// File: tb/tb_bounce_counter.sv
// tb_bounce_counter: scoreboard bench for two counter instances (0..15 and 3..6)
module tb_bounce_counter;
    typedef struct {int c; int d; int e;} exp_t;
    logic       clk = 1'b0;
    logic       rst_btn = 1'b0;
    logic       en_a = 1'b0, load_a = 1'b0, en_b = 1'b0, load_b = 1'b0;
    logic [1:0] mode_a = 2'b00, mode_b = 2'b10;
    logic [3:0] lv_a = '0, lv_b = '0;
    logic [3:0] count_a, count_b;
    logic       dir_a, tick_a, edge_a, dir_b, tick_b, edge_b;
    logic       arm_a = 1'b0, arm_b = 1'b0;
    exp_t       qa[$], qb[$];
    exp_t       ea, eb;
    int         n_chk = 0, n_pass = 0, n;
    bounce_counter #(.WIDTH(4), .MIN_COUNT(0), .MAX_COUNT(15), .DIV_COUNT(4)) dut_a (
        .clk(clk), .rst_btn(rst_btn), .en(en_a), .mode(mode_a), .load(load_a), .load_val(lv_a),
        .count(count_a), .dir(dir_a), .tick(tick_a), .edge_p(edge_a)
    );
    bounce_counter #(.WIDTH(4), .MIN_COUNT(3), .MAX_COUNT(6), .DIV_COUNT(4)) dut_b (
        .clk(clk), .rst_btn(rst_btn), .en(en_b), .mode(mode_b), .load(load_b), .load_val(lv_b),
        .count(count_b), .dir(dir_b), .tick(tick_b), .edge_p(edge_b)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask
    task automatic push(input bit b, input int c, input int d, input int e);
        if (b) qb.push_back('{c, d, e});
        else qa.push_back('{c, d, e});
    endtask
    task automatic wait_tick(input bit b, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(b ? tick_b : tick_a) && k < 20);
    endtask
    task automatic run(input bit b, input int steps);
        int bad = 0, k;
        for (int i = 0; i < steps; i++) begin
            wait_tick(b, k);
            if (k != 4) bad++;
        end
        check(b ? "b_tick_period" : "a_tick_period", bad, 0);
    endtask
    task automatic stop(input bit b);
        @(negedge clk);
        if (b) en_b = 1'b0;
        else en_a = 1'b0;
        @(negedge clk);
        check(b ? "b_sb_drain" : "a_sb_drain", b ? qb.size() : qa.size(), 0);
    endtask
    // scoreboard: a tick seen with en and no load means the next negedge shows a step
    always begin
        @(negedge clk);
        #1;
        if (arm_a) begin
            if (qa.size() == 0) check("a_sb_empty", 1, 0);
            else begin
                ea = qa.pop_front();
                check("a_count", int'(count_a), ea.c);
                check("a_dir", int'(dir_a), ea.d);
                check("a_edge", int'(edge_a), ea.e);
            end
        end
        if (arm_b) begin
            if (qb.size() == 0) check("b_sb_empty", 1, 0);
            else begin
                eb = qb.pop_front();
                check("b_count", int'(count_b), eb.c);
                check("b_dir", int'(dir_b), eb.d);
                check("b_edge", int'(edge_b), eb.e);
            end
        end
        arm_a = tick_a && en_a && !load_a;
        arm_b = tick_b && en_b && !load_b;
    end
    initial begin
        int bad;
        repeat (3) @(negedge clk);
        check("rst_count_a", int'(count_a), 0);
        check("rst_dir_a", int'(dir_a), 1);
        check("rst_tick_a", int'(tick_a), 0);
        check("rst_edge_a", int'(edge_a), 0);
        check("rst_count_b", int'(count_b), 3);
        rst_btn = 1'b1;
        @(negedge clk);
        foreach (qb[i]) qb.delete(i);
        push(1, 4, 1, 0); push(1, 5, 1, 0); push(1, 6, 0, 1); push(1, 5, 0, 0);
        push(1, 4, 0, 0); push(1, 3, 1, 1); push(1, 4, 1, 0);
        en_b = 1'b1;
        run(1, 7);
        stop(1);
        lv_b = 4'd9; load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        check("b_load_clamp_hi", int'(count_b), 6);
        lv_b = 4'd0; load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        check("b_load_clamp_lo", int'(count_b), 3);
        for (int i = 1; i <= 16; i++) push(0, i % 16, 1, int'(i == 16));
        en_a = 1'b1;
        wait_tick(0, n);
        check("a_first_tick", n, 4);
        run(0, 15);
        stop(0);
        mode_a = 2'b10;
        for (int i = 1; i <= 15; i++) push(0, i, int'(i != 15), int'(i == 15));
        for (int i = 14; i >= 0; i--) push(0, i, int'(i == 0), int'(i == 0));
        push(0, 1, 1, 0);
        en_a = 1'b1;
        run(0, 31);
        stop(0);
        for (int i = 2; i <= 5; i++) push(0, i, 1, 0);
        en_a = 1'b1;
        run(0, 4);
        stop(0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (tick_a || count_a != 4'd5) bad++;
        end
        check("a_en0_freeze", bad, 0);
        push(0, 6, 1, 0);
        en_a = 1'b1;
        wait_tick(0, n);
        check("a_en_restart", n, 4);
        stop(0);
        push(0, 7, 1, 0);
        en_a = 1'b1;
        run(0, 1);
        wait_tick(0, n);
        check("a_tick_at_7", n, 4);
        check("a_count_at_load", int'(count_a), 7);
        lv_a = 4'd2; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        check("a_load_count", int'(count_a), 2);
        check("a_load_dir", int'(dir_a), 1);
        check("a_load_edge", int'(edge_a), 0);
        push(0, 3, 1, 0);
        wait_tick(0, n);
        check("a_load_restart", n, 4);
        stop(0);
        mode_a = 2'b11;
        push(0, 3, 1, 0); push(0, 3, 1, 0);
        en_a = 1'b1;
        run(0, 2);
        stop(0);
        mode_a = 2'b01;
        lv_a = 4'd1; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        check("a_load_en0", int'(count_a), 1);
        push(0, 0, 0, 0); push(0, 15, 0, 1); push(0, 14, 0, 0);
        en_a = 1'b1;
        run(0, 3);
        stop(0);
        mode_a = 2'b10;
        push(0, 13, 0, 0); push(0, 12, 0, 0);
        en_a = 1'b1;
        run(0, 2);
        @(negedge clk);
        #2 rst_btn = 1'b0;
        #1;
        check("a_async_count", int'(count_a), 0);
        check("a_async_dir", int'(dir_a), 1);
        check("a_async_tick", int'(tick_a), 0);
        check("a_async_sb", qa.size(), 0);
        en_a = 1'b0;
        @(negedge clk);
        rst_btn = 1'b1;
        mode_a = 2'b00;
        push(0, 1, 1, 0);
        en_a = 1'b1;
        wait_tick(0, n);
        check("a_post_rst_tick", n, 4);
        stop(0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
